// File: rtl/perf_counter_snapshot.sv
// Atomic snapshot of a performance-counter bank, served as 32-bit words on a read port.
// Define PERF_SNAPSHOT_DELTA_EN to report deltas since the previous snapshot instead of absolute counts.
module perf_counter_snapshot #(
    parameter int unsigned NUM_COUNTERS = 8,
    parameter int unsigned COUNT_WIDTH  = 64
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [NUM_COUNTERS*COUNT_WIDTH-1:0]   counts,
    input  logic                                  snap_req,
    output logic                                  snap_busy,
    output logic                                  snap_done,
    output logic [15:0]                           snap_seq,
    input  logic                                  rd_en,
    input  logic [$clog2(NUM_COUNTERS):0]         rd_addr,
    output logic                                  rd_valid,
    output logic [31:0]                           rd_data
);

    localparam int unsigned AW = $clog2(NUM_COUNTERS) + 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_CAPTURE  = 2'd1;
`ifdef PERF_SNAPSHOT_DELTA_EN
    localparam logic [1:0] S_SUBTRACT = 2'd2;
    localparam int unsigned IW = $clog2(NUM_COUNTERS + 1);
`endif
    localparam logic [1:0] S_DONE     = 2'd3;

    logic [1:0]             r_state;
    logic [1:0]             w_state_nxt;
    logic [COUNT_WIDTH-1:0] r_cap    [NUM_COUNTERS];
    logic [COUNT_WIDTH-1:0] r_shadow [NUM_COUNTERS];
    logic                   r_busy;
    logic                   r_done;
    logic [15:0]            r_seq;
    logic                   r_pend;
    logic [AW-1:0]          r_pend_addr;
    logic                   r_rd_valid;
    logic [31:0]            r_rd_data;
    logic [AW-1:0]          w_addr;
    logic [AW-1:0]          w_idx;
    logic [63:0]            w_ext;
    logic [31:0]            w_rd_word;
`ifdef PERF_SNAPSHOT_DELTA_EN
    logic [COUNT_WIDTH-1:0] r_prev [NUM_COUNTERS];
    logic [COUNT_WIDTH-1:0] r_diff;
    logic [IW-1:0]          r_idx;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     if (snap_req) w_state_nxt = S_CAPTURE;
`ifdef PERF_SNAPSHOT_DELTA_EN
            S_CAPTURE:  w_state_nxt = S_SUBTRACT;
            // r_idx == N means the last difference is being written back
            S_SUBTRACT: if (r_idx == IW'(NUM_COUNTERS)) w_state_nxt = S_DONE;
`else
            S_CAPTURE:  w_state_nxt = S_DONE;
`endif
            S_DONE:     w_state_nxt = S_IDLE;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // Read mux: a pending read uses its latched address
    always_comb begin
        w_addr = r_pend ? r_pend_addr : rd_addr;
        w_idx  = w_addr >> 1;
        w_ext  = '0;
        for (int i = 0; i < NUM_COUNTERS; i++) begin
            if (w_idx == AW'(i)) w_ext = 64'(r_shadow[i]);
        end
        w_rd_word = w_addr[0] ? w_ext[63:32] : w_ext[31:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_seq       <= '0;
            r_pend      <= 1'b0;
            r_pend_addr <= '0;
            r_rd_valid  <= 1'b0;
            r_rd_data   <= '0;
        end else begin
            r_busy <= (w_state_nxt != S_IDLE);
            r_done <= (w_state_nxt == S_DONE);
            if (w_state_nxt == S_DONE) r_seq <= r_seq + 16'd1;
            if (r_state == S_IDLE) begin
                r_rd_valid <= r_pend || rd_en;
                if (r_pend || rd_en) r_rd_data <= w_rd_word;
                r_pend <= 1'b0;
            end else begin
                r_rd_valid <= 1'b0;
                if (rd_en && !r_pend) begin
                    r_pend      <= 1'b1;
                    r_pend_addr <= rd_addr;
                end
            end
        end
    end

    // Capture bank also serves as the raw bank in delta mode
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_COUNTERS; i++) begin
                r_cap[i]    <= '0;
                r_shadow[i] <= '0;
`ifdef PERF_SNAPSHOT_DELTA_EN
                r_prev[i]   <= '0;
`endif
            end
`ifdef PERF_SNAPSHOT_DELTA_EN
            r_diff <= '0;
            r_idx  <= '0;
`endif
        end else begin
            if (r_state == S_IDLE && snap_req) begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    r_cap[i] <= counts[i*COUNT_WIDTH +: COUNT_WIDTH];
                end
            end
`ifdef PERF_SNAPSHOT_DELTA_EN
            if (r_state == S_CAPTURE) begin
                r_idx <= '0;
            end else if (r_state == S_SUBTRACT) begin
                r_idx <= r_idx + IW'(1);
                // Two-stage: compute difference for r_idx, write back the one before it
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    if (r_idx == IW'(i)) begin
                        r_diff    <= r_cap[i] - r_prev[i];
                        r_prev[i] <= r_cap[i];
                    end
                    if (r_idx == IW'(i + 1)) r_shadow[i] <= r_diff;
                end
            end
`else
            if (r_state == S_CAPTURE) begin
                for (int i = 0; i < NUM_COUNTERS; i++) begin
                    r_shadow[i] <= r_cap[i];
                end
            end
`endif
        end
    end

    assign snap_busy = r_busy;
    assign snap_done = r_done;
    assign snap_seq  = r_seq;
    assign rd_valid  = r_rd_valid;
    assign rd_data   = r_rd_data;

endmodule
